// File: rtl/fft_pkg.sv
// Shared FFT constants, the unload FSM state type, and the bit-reversal helper.
package fft_pkg;

  localparam int unsigned FFT_N      = 32;
  localparam int unsigned FFT_ADDR_W = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  // Reverse the low 'width' bits of addr; bits above 'width' come back zero.
  function automatic logic [31:0] bitrev(input logic [31:0] addr,
                                         input int unsigned width = FFT_ADDR_W);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < width; i++) begin
      r[5'(i)] = addr[5'(width - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_output_reader_fifo.sv
// 4-deep synchronous FIFO carrying {data, bin index} from the memory read
// side to the output stream; cleared by the asynchronous reset.
module stream_fifo4 #(
  parameter int unsigned W = 37
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic [2:0]   o_count
);

  logic [W-1:0] r_mem [4];
  logic [1:0]   r_wr_ptr;
  logic [1:0]   r_rd_ptr;
  logic [2:0]   r_count;
  logic         w_push;
  logic         w_pop;

  assign w_push  = i_push && (r_count != 3'd4);
  assign w_pop   = i_pop && (r_count != 3'd0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage, pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem    <= '{default: '0};
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      r_count <= r_count + 3'(w_push) - 3'(w_pop);
    end
  end

endmodule

// File: rtl/fft_output_reader.sv
// Unloads FFT results from data memory in bit-reversed address order after
// the rising edge of fft_done and streams them in natural bin order.
module fft_output_reader
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned BIT_REVERSE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fft_done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              unload_done
);

  localparam logic [ADDR_W-1:0] LAST_K = '1;

  state_t                     r_state;
  state_t                     w_next;
  logic                       r_done_q;
  logic                       r_inflight;
  logic [ADDR_W-1:0]          r_rd_cnt;
  logic [ADDR_W-1:0]          r_tag_k;
  logic                       w_start;
  logic                       w_rd_en;
  logic                       w_pop;
  logic [2:0]                 w_count;
  logic [DATA_W+ADDR_W-1:0]   w_head;

  assign w_start = fft_done & ~r_done_q;

  // Credit check counts the read still in flight so the FIFO cannot overflow
  // even when the output is stalled.
  assign w_rd_en = (r_state == S_READ) && ((w_count + {2'b00, r_inflight}) < 3'd4);

  assign mem_rd_en   = w_rd_en;
  assign mem_rd_addr = (BIT_REVERSE != 0) ? ADDR_W'(bitrev(32'(r_rd_cnt), ADDR_W))
                                          : r_rd_cnt;

  assign out_valid   = (w_count != 3'd0);
  assign out_data    = w_head[DATA_W+ADDR_W-1:ADDR_W];
  assign out_index   = w_head[ADDR_W-1:0];
  assign out_last    = out_valid && (out_index == LAST_K);
  assign w_pop       = out_valid & out_ready;
  assign busy        = (r_state != S_IDLE);
  assign unload_done = (r_state == S_DONE);

  // State register and fft_done edge-detect history (reset high to mask a
  // level already present at reset release).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_done_q <= 1'b1;
    end else begin
      r_state  <= w_next;
      r_done_q <= fft_done;
    end
  end

  // Read counter, tag for the in-flight read, and in-flight flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_cnt   <= '0;
      r_tag_k    <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_rd_en) begin
        r_tag_k <= r_rd_cnt;
      end
      if ((r_state == S_IDLE) && w_start) begin
        r_rd_cnt <= '0;
      end else if (w_rd_en && (r_rd_cnt != LAST_K)) begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end
    end
  end

  // Next-state logic for the unload sequence.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start) w_next = S_READ;
      S_READ:  if (w_rd_en && (r_rd_cnt == LAST_K)) w_next = S_DRAIN;
      S_DRAIN: if (out_last && out_ready) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  stream_fifo4 #(
    .W(DATA_W + ADDR_W)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (r_inflight),
    .i_data ({mem_rd_data, r_tag_k}),
    .i_pop  (w_pop),
    .o_data (w_head),
    .o_count(w_count)
  );

endmodule
